seg_scan_driver: RTL and testbench



---
 rtl/seg_scan_driver_pkg.sv | 38 +++
 rtl/seg_scan_driver_if.sv | 24 ++
 rtl/seg_scan_driver_tick_divider.sv | 27 ++
 rtl/seg_scan_driver.sv | 93 +++++++++
 tb/tb_seg_scan_driver.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/seg_scan_driver_pkg.sv
// Shared display definitions: BCD to seven-segment table, segment constants, digit slots.
// Latency: none (constants and a combinational function only).
// Backpressure: not applicable.
package seg_scan_driver_pkg;

    localparam int NUM_DIGITS = 6;

    // Digit slot numbers; slot i is driven by an[i] and digits[4*i +: 4].
    localparam logic [2:0] DIG_SEC_ONES  = 3'd0;
    localparam logic [2:0] DIG_SEC_TENS  = 3'd1;
    localparam logic [2:0] DIG_MIN_ONES  = 3'd2;
    localparam logic [2:0] DIG_MIN_TENS  = 3'd3;
    localparam logic [2:0] DIG_HOUR_ONES = 3'd4;
    localparam logic [2:0] DIG_HOUR_TENS = 3'd5;

    localparam logic [6:0] SEG_ALL_ON = 7'b1111111;
    localparam logic [6:0] SEG_OFF    = 7'b0000000;

    // Active-high segments, bit0=a .. bit6=g. Non-BCD codes render dark.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        logic [6:0] s;
        case (bcd)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            default: s = SEG_OFF;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Display-stage bundle: BCD digits and status in, multiplexed segment drive out.
// Latency: not applicable (wiring only).
// Backpressure: none; inputs are sampled every cycle, outputs always valid.
interface seg_scan_driver_if;
    logic [23:0] digits;
    logic [5:0]  blank_mask;
    logic [5:0]  blink_mask;
    logic        alarm_flash;
    logic [6:0]  seg;
    logic [5:0]  an;
    logic        frame_start;

    // Upstream clock core / bench side.
    modport master (
        output digits, blank_mask, blink_mask, alarm_flash,
        input  seg, an, frame_start
    );

    // Scan driver side.
    modport slave (
        input  digits, blank_mask, blink_mask, alarm_flash,
        output seg, an, frame_start
    );
endinterface

// File: rtl/seg_scan_driver_tick_divider.sv
// Modulo-N counter producing a one-cycle wrap strobe on its last count.
// Latency: wrap is combinational from the count register.
// Backpressure: none; en pauses counting.
module seg_scan_driver_tick_divider #(
    parameter int unsigned N = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic wrap
);
    localparam int unsigned W = (N > 1) ? $clog2(N) : 1;
    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] cnt;

    assign wrap = en && (cnt == LAST);

    // Count 0..N-1 while enabled, returning to zero on the wrap cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= wrap ? '0 : cnt + 1'b1;
        end
    end
endmodule

// File: rtl/seg_scan_driver.sv
// Six-digit multiplexed seven-segment driver with per-frame digit snapshot, blanking, blink and alarm flash.
// Latency: an/seg/frame_start register one cycle behind the scan index; first digit lit two edges after reset.
// Backpressure: none; masks and flash are sampled live every cycle, digits once per frame.
module seg_scan_driver
    import seg_scan_driver_pkg::*;
#(
    parameter int unsigned SCAN_DIV  = 2,
    parameter int unsigned BLINK_DIV = 500
) (
    input  logic              clk,
    input  logic              rst,
    seg_scan_driver_if.slave  bus
);
    logic        primed;
    logic [2:0]  idx;
    logic [23:0] snap;
    logic        blink_on;
    logic        slot_first;
    logic        scan_wrap;
    logic        blink_wrap;
    logic [3:0]  nib;
    logic [6:0]  seg_nxt;

    // Scan timing only starts once the first snapshot exists.
    seg_scan_driver_tick_divider #(.N(SCAN_DIV)) u_scan_div (
        .clk  (clk),
        .rst  (rst),
        .en   (primed),
        .wrap (scan_wrap)
    );

    // Blink phase runs free, independent of the scan position.
    seg_scan_driver_tick_divider #(.N(BLINK_DIV)) u_blink_div (
        .clk  (clk),
        .rst  (rst),
        .en   (1'b1),
        .wrap (blink_wrap)
    );

    // Scan index, frame snapshot, blink phase and first-cycle-of-slot flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            primed     <= 1'b0;
            idx        <= DIG_SEC_ONES;
            snap       <= '0;
            blink_on   <= 1'b1;
            slot_first <= 1'b0;
        end else begin
            primed     <= 1'b1;
            slot_first <= !primed || scan_wrap;
            if (!primed) begin
                snap <= bus.digits;
            end
            if (scan_wrap) begin
                if (idx == DIG_HOUR_TENS) begin
                    idx  <= DIG_SEC_ONES;
                    snap <= bus.digits;
                end else begin
                    idx <= idx + 3'd1;
                end
            end
            if (blink_wrap) begin
                blink_on <= !blink_on;
            end
        end
    end

    // Segment pattern for the current slot: flash beats blank beats blink beats decode.
    always_comb begin
        nib     = snap[{idx, 2'b00} +: 4];
        seg_nxt = bcd_to_seg(nib);
        if (bus.alarm_flash && blink_on) begin
            seg_nxt = SEG_ALL_ON;
        end else if (bus.blank_mask[idx]) begin
            seg_nxt = SEG_OFF;
        end else if (bus.blink_mask[idx] && !blink_on) begin
            seg_nxt = SEG_OFF;
        end
    end

    // Registered display drive; stays dark until the scan is primed.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.an          <= '0;
            bus.seg         <= SEG_OFF;
            bus.frame_start <= 1'b0;
        end else if (primed) begin
            bus.an          <= 6'b000001 << idx;
            bus.seg         <= seg_nxt;
            bus.frame_start <= slot_first && (idx == DIG_SEC_ONES);
        end
    end
endmodule

// File: tb/tb_seg_scan_driver.sv
module tb_seg_scan_driver;
    localparam int SD = 2;
    localparam int BD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    // Reference model state: edges since reset release and the frame snapshot.
    int          k = 0;
    logic [23:0] snap_m = '0;
    int          exp_slot = -1;
    logic [5:0]  exp_an = '0;
    logic [6:0]  exp_seg = '0;
    logic        exp_fs = 1'b0;
    logic [6:0]  seg_tab [16];

    seg_scan_driver_if bus ();

    seg_scan_driver #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [6:0] got, input logic [6:0] expv);
        tests++;
        assert (got === expv) else begin
            fails++;
            $error("FAIL %s k=%0d got %b expected %b", tag, k, got, expv);
        end
    endtask

    // One clock edge: predict outputs from the behavioural rules, then compare.
    task automatic tick();
        int  p;
        bit  on;
        logic [3:0] nib;
        @(posedge clk);
        if (rst) begin
            k = 0; exp_slot = -1; exp_an = '0; exp_seg = '0; exp_fs = 1'b0;
        end else begin
            k++;
            if (k == 1) begin
                exp_slot = -1; exp_an = '0; exp_seg = '0; exp_fs = 1'b0;
                snap_m = bus.digits;
            end else begin
                p        = k - 2;
                exp_slot = (p / SD) % 6;
                exp_fs   = ((p % (6 * SD)) == 0);
                on       = (((k - 1) / BD) % 2) == 0;
                nib      = snap_m[exp_slot*4 +: 4];
                exp_an   = 6'(1 << exp_slot);
                if (bus.alarm_flash && on)             exp_seg = 7'h7F;
                else if (bus.blank_mask[exp_slot])     exp_seg = 7'h00;
                else if (bus.blink_mask[exp_slot] && !on) exp_seg = 7'h00;
                else                                   exp_seg = seg_tab[nib];
                if (((k - 1) % (6 * SD)) == 0) snap_m = bus.digits;
            end
        end
        #1;
        check("an", {1'b0, bus.an}, {1'b0, exp_an});
        check("seg", bus.seg, exp_seg);
        check("frame_start", {6'b0, bus.frame_start}, {6'b0, exp_fs});
    endtask

    task automatic run_until_slot(input int s);
        for (int i = 0; i < 16 && exp_slot != s; i++) tick();
    endtask

    task automatic run_until_fs();
        tick();
        for (int i = 0; i < 16 && !exp_fs; i++) tick();
    endtask

    initial begin
        seg_tab[0] = 7'b0111111; seg_tab[1] = 7'b0000110; seg_tab[2] = 7'b1011011;
        seg_tab[3] = 7'b1001111; seg_tab[4] = 7'b1100110; seg_tab[5] = 7'b1101101;
        seg_tab[6] = 7'b1111101; seg_tab[7] = 7'b0000111; seg_tab[8] = 7'b1111111;
        seg_tab[9] = 7'b1101111;
        for (int i = 10; i < 16; i++) seg_tab[i] = 7'b0000000;

        bus.digits = 24'h235958; bus.blank_mask = '0; bus.blink_mask = '0; bus.alarm_flash = 1'b0;

        // Reset held three cycles.
        rst = 1'b1;
        repeat (3) tick();
        check("rst_an", {1'b0, bus.an}, 7'd0);

        // Start-up and digit mapping.
        rst = 1'b0;
        tick();
        check("edge1_an", {1'b0, bus.an}, 7'd0);
        tick();
        check("edge2_an", {1'b0, bus.an}, 7'b0000001);
        check("edge2_fs", {6'b0, bus.frame_start}, 7'd1);
        check("slot0_8", bus.seg, 7'b1111111);
        tick(); tick();
        check("edge4_an", {1'b0, bus.an}, 7'b0000010);
        run_until_slot(2);
        check("slot2_9", bus.seg, 7'b1101111);
        run_until_slot(5);
        check("slot5_2", bus.seg, 7'b1011011);
        repeat (14) tick();

        // Snapshot coherence across a mid-frame digit change.
        bus.digits = 24'h000000;
        run_until_fs();
        run_until_slot(2);
        bus.digits = 24'h111111;
        run_until_slot(3);
        check("snap_slot3", bus.seg, 7'b0111111);
        run_until_slot(5);
        check("snap_slot5", bus.seg, 7'b0111111);
        run_until_fs();
        check("snap_new", bus.seg, 7'b0000110);

        // Blink on slot 2.
        bus.digits = 24'h000007; bus.blink_mask = 6'b000100;
        repeat (40) tick();

        // Alarm flash over full blanking, then a non-BCD nibble.
        bus.blink_mask = '0; bus.alarm_flash = 1'b1; bus.blank_mask = 6'b111111;
        repeat (24) tick();
        bus.alarm_flash = 1'b0; bus.blank_mask = '0; bus.digits = 24'h00000A;
        run_until_fs();
        run_until_fs();
        check("nibble_A", bus.seg, 7'b0000000);

        // Mid-scan reset at slot 4.
        bus.digits = 24'h123456;
        run_until_slot(4);
        rst = 1'b1;
        tick();
        check("midrst_an", {1'b0, bus.an}, 7'd0);
        check("midrst_seg", bus.seg, 7'd0);
        rst = 1'b0;
        tick(); tick();
        check("restart_fs", {6'b0, bus.frame_start}, 7'd1);
        check("restart_seg", bus.seg, 7'b1111101);
        repeat (10) tick();

        // Randomized inputs, including occasional resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                for (int d = 0; d < 6; d++)
                    bus.digits[d*4 +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                                      : 4'($urandom_range(0, 9));
            end
            if ($urandom_range(0, 7) == 0) bus.blank_mask = 6'($urandom);
            if ($urandom_range(0, 7) == 0) bus.blink_mask = 6'($urandom);
            if ($urandom_range(0, 9) == 0) bus.alarm_flash = 1'($urandom);
            rst = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 1'b0;
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
